dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the processor data port and a
//  DMA/debug loader port. Arbitration is decided every cycle. CPU has
//  priority; a starvation counter guarantees DMA progress. Sits between mips
//  and dmem in top; read data returns one cycle after the grant (sync-read RAM).
// PARAMETERS
//  AW        32  address width (byte address, passed through unchanged)
//  DW        32  data width
//  BURST_MAX 4   max consecutive contested CPU wins before DMA is forced a slot (>=1)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  cpu_req     in   1   CPU access request, held until cpu_gnt
//  cpu_we      in   1   1=write, 0=read
//  cpu_addr    in   AW  CPU address
//  cpu_wdata   in   DW  CPU write data
//  cpu_gnt     out  1   CPU access performed this cycle
//  cpu_rvalid  out  1   cpu_rdata valid (cycle after a granted CPU read)
//  cpu_rdata   out  DW  CPU read data
//  dma_req/dma_we/dma_addr/dma_wdata  in  1/1/AW/DW  DMA request, same rules as CPU
//  dma_gnt     out  1   DMA access performed this cycle
//  dma_rvalid  out  1   dma_rdata valid
//  dma_rdata   out  DW  DMA read data
//  mem_we      out  1   memory write enable
//  mem_addr    out  AW  memory address
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory read data, valid the cycle after the address
// BEHAVIOUR
//  - Reset (reset=0, async): all gnt/rvalid=0, rdata=0, starve_cnt=0, rd_pending=0.
//    Any in-flight read is dropped; no rvalid after reset release for it.
//  - Grant (combinational from req + starve_cnt, at most one gnt per cycle):
//    only cpu_req -> CPU; only dma_req -> DMA; both (contested) -> CPU
//    unless starve_cnt==BURST_MAX, then DMA. Neither -> no gnt, mem_we=0.
//  - mem_we/addr/wdata = granted master's we/addr/wdata; with no gnt, mem_we=0
//    and addr/wdata = CPU fields.
//  - starve_cnt (clog2(BURST_MAX+1) bits): +1 on contested CPU win; cleared
//    on any DMA grant or any cycle dma_req=0; never exceeds BURST_MAX.
//  - Read return: on granted read, register rd_pending=1, rd_owner=winner.
//    Next cycle: owner's rvalid=1, owner's rdata<=mem_rdata (registered, held
//    until next read to that owner); other master's rvalid=0. Writes give no rvalid.
//  - Back-to-back reads, even alternating owners, sustain one access/cycle;
//    each rvalid maps to the grant one cycle earlier.
//  - Write then read same address on consecutive grants returns the new data
//    (memory write-first ordering; arbiter adds no buffering).
//  - Requests are not queued: ungranted master holds req and fields stable.
//  - Latency: gnt 0 cycles after req (if won); rdata 1 cycle after gnt.
// STRUCTURE
//  - Shared package: OWN_CPU=1'b0, OWN_DMA=1'b1 owner encoding; default widths.
//  - One sub-module dmem_arb_pick: grant decision + starve_cnt register.
//    Top level: mux, rd_pending/rd_owner, rdata/rvalid registers.
// TESTING
//  1 Reset mid-read: CPU read gnt @t, reset=0 @t+0.5 -> cpu_rvalid stays 0,
//    all outputs 0 until first new grant.
//  2 CPU only: write 0x10<-0xDEADBEEF, then read 0x10 -> gnt each cycle,
//    cpu_rvalid next cycle with 0xDEADBEEF; dma_rvalid=0 throughout.
//  3 Contested, BURST_MAX=4, both req continuously -> grant pattern
//    C,C,C,C,D repeating; DMA never waits more than 4 cycles.
//  4 dma_req drops for 1 cycle after 3 CPU wins -> starve_cnt clears; next
//    contested run again gives 4 CPU wins first.
//  5 Alternating reads C@0x20, D@0x24, C@0x28 in consecutive cycles ->
//    rvalid on cpu, dma, cpu in the next 3 cycles with matching data.
//  6 BURST_MAX=1, both req -> strict alternation C,D,C,D.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding and default widths.
package dmem_arbiter_pkg;

    localparam int unsigned DEF_AW        = 32;
    localparam int unsigned DEF_DW        = 32;
    localparam int unsigned DEF_BURST_MAX = 4;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Per-cycle grant decision between CPU and DMA, with a starvation counter that
// forces a DMA slot after BURST_MAX consecutive contested CPU wins.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic dma_req,
    output logic cpu_gnt_c,
    output logic dma_gnt_c
);

    localparam int unsigned CW = $clog2(BURST_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved_c;

    assign starved_c = (starve_cnt == CW'(BURST_MAX));

    // Grants are suppressed while reset is held so the memory sees no access.
    always_comb begin
        dma_gnt_c = 1'b0;
        cpu_gnt_c = 1'b0;
        if (reset) begin
            dma_gnt_c = dma_req & (~cpu_req | starved_c);
            cpu_gnt_c = cpu_req & ~dma_gnt_c;
        end
    end

    // A CPU grant while DMA is also requesting is a contested win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_gnt_c) begin
            starve_cnt <= '0;
        end else if (cpu_gnt_c) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port sync-read data memory between the CPU data port and the
// DMA/debug loader port; read data returns one cycle after the grant.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic          rd_pending;
    owner_e        rd_owner;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    dmem_arb_pick #(
        .BURST_MAX (BURST_MAX)
    ) u_pick (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .cpu_gnt_c (cpu_gnt),
        .dma_gnt_c (dma_gnt)
    );

    // Idle cycles present the CPU fields with the write strobe low.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_gnt) begin
            mem_we = cpu_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_CPU;
        end else begin
            rd_pending <= (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
            if (cpu_gnt || dma_gnt) begin
                rd_owner <= dma_gnt ? OWN_DMA : OWN_CPU;
            end
        end
    end

    assign cpu_rvalid = rd_pending & (rd_owner == OWN_CPU);
    assign dma_rvalid = rd_pending & (rd_owner == OWN_DMA);

    // Returned word is forwarded while valid and held afterwards until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dma_rvalid) dma_rdata_q <= mem_rdata;
        end
    end

    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata = dma_rvalid ? mem_rdata : dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration model and a shadow memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;

    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic        b1_cpu_gnt, b1_cpu_rvalid, b1_dma_gnt, b1_dma_rvalid, b1_mem_we;
    logic [31:0] b1_cpu_rdata, b1_dma_rdata, b1_mem_addr, b1_mem_wdata;
    logic [31:0] b1_mem_rdata = '0;

    dmem_arbiter #(.AW(32), .DW(32), .BURST_MAX(4)) dut (
        .clk(clk), .reset(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.AW(32), .DW(32), .BURST_MAX(1)) dut_b1 (
        .clk(clk), .reset(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(b1_cpu_gnt), .cpu_rvalid(b1_cpu_rvalid), .cpu_rdata(b1_cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(b1_dma_gnt), .dma_rvalid(b1_dma_rvalid), .dma_rdata(b1_dma_rdata),
        .mem_we(b1_mem_we), .mem_addr(b1_mem_addr), .mem_wdata(b1_mem_wdata),
        .mem_rdata(b1_mem_rdata)
    );

    always #5 clk = ~clk;

    // Sync-read, write-first RAM behind the main arbiter.
    logic [31:0] ram [logic [31:0]];
    always @(posedge clk) begin
        mem_rdata <= mem_we ? mem_wdata : (ram.exists(mem_addr) ? ram[mem_addr] : 32'h0);
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else
            passed++;
    endtask

    // Reference model state
    typedef struct {
        bit          dma;
        logic [31:0] data;
        int          due;
    } rd_t;
    rd_t         sb[$];
    logic [31:0] shadow [logic [31:0]];
    int          wins4 = 0;
    int          wins1 = 0;
    bit          last_cg, last_dg;
    bit          pat4[$];
    bit          pat1[$];

    // DMA wins when CPU is idle or CPU has already taken bm contested slots in a row.
    function automatic bit dma_wins(input bit c, input bit d, input int wins, input int bm);
        return d && (!c || wins >= bm);
    endfunction

    task automatic check_cycle();
        bit          edg, ecg, e1d, e1c, we;
        logic [31:0] a, wd;
        edg = dma_wins(cpu_req, dma_req, wins4, 4);
        ecg = cpu_req && !edg;
        chk("cpu_gnt", cpu_gnt, ecg);
        chk("dma_gnt", dma_gnt, edg);
        we = edg ? dma_we : (ecg ? cpu_we : 1'b0);
        a  = edg ? dma_addr : cpu_addr;
        wd = edg ? dma_wdata : cpu_wdata;
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, a);
        if (we) chk("mem_wdata", mem_wdata, wd);
        if (ecg || edg) begin
            if (we) shadow[a] = wd;
            else sb.push_back('{edg, (shadow.exists(a) ? shadow[a] : 32'h0), cyc + 1});
        end
        if (!dma_req || edg) wins4 = 0;
        else if (ecg) wins4++;
        pat4.push_back(dma_gnt);
        last_cg = ecg;
        last_dg = edg;

        e1d = dma_wins(cpu_req, dma_req, wins1, 1);
        e1c = cpu_req && !e1d;
        chk("b1_cpu_gnt", b1_cpu_gnt, e1c);
        chk("b1_dma_gnt", b1_dma_gnt, e1d);
        chk("b1_mem_addr", b1_mem_addr, e1d ? dma_addr : cpu_addr);
        if (!dma_req || e1d) wins1 = 0;
        else if (e1c) wins1++;
        pat1.push_back(b1_dma_gnt);
    endtask

    task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, cpu_addr, cpu_wdata, 1'b0, 1'b0, dma_addr, dma_wdata);
    endtask

    // Monitor: every cycle out of reset, rvalid must match the read granted one cycle earlier.
    initial begin
        rd_t         it;
        bit          ec, ed;
        logic [31:0] ev;
        forever begin
            @(posedge clk);
            #3;
            if (rst_n) begin
                ec = 0; ed = 0; ev = '0;
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    it = sb.pop_front();
                    ed = it.dma;
                    ec = !it.dma;
                    ev = it.data;
                end
                chk("cpu_rvalid", cpu_rvalid, ec);
                chk("dma_rvalid", dma_rvalid, ed);
                if (ec) chk("cpu_rdata", cpu_rdata, ev);
                if (ed) chk("dma_rdata", dma_rdata, ev);
            end
        end
    end

    initial begin
        bit          cp, dp, cwe, dwe;
        logic [31:0] ca, cd, da, dd;

        // Reset state with a CPU request already asserted
        cpu_req = 1'b1;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // CPU-only write then read back
        step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
        step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        idle();
        chk("t2_rdata_held", cpu_rdata, 32'hDEADBEEF);

        // Reset in the middle of a granted CPU read drops the return
        step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t1_cpu_gnt", cpu_gnt, 0);
        chk("t1_cpu_rdata", cpu_rdata, 0);
        chk("t1_cpu_rvalid", cpu_rvalid, 0);
        chk("t1_mem_we", mem_we, 0);
        sb.delete();
        wins4 = 0;
        wins1 = 0;
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        chk("t1_rdata_after", cpu_rdata, 0);

        // Continuous contention: 4:1 on the main arbiter, strict alternation with BURST_MAX=1
        idle();
        pat4.delete(); pat1.delete();
        repeat (10) step(1, 0, 32'h10, 32'h0, 1, 1, 32'h30, 32'h5A5A0001);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_dma_slot%0d", i), 32'(pat4[i]), 32'((i % 5) == 4));
            chk($sformatf("t6_dma_slot%0d", i), 32'(pat1[i]), 32'((i % 2) == 1));
        end

        // A one-cycle drop of dma_req clears the starvation history
        idle();
        pat4.delete();
        repeat (3) step(1, 0, 32'h14, 32'h0, 1, 0, 32'h34, 32'h0);
        step(1, 0, 32'h14, 32'h0, 0, 0, 32'h34, 32'h0);
        repeat (5) step(1, 0, 32'h14, 32'h0, 1, 0, 32'h34, 32'h0);
        for (int i = 0; i < 9; i++)
            chk($sformatf("t4_dma_slot%0d", i), 32'(pat4[i]), 32'(i == 8));

        // Alternating-owner back-to-back reads
        step(1, 1, 32'h20, 32'hA1A1A1A1, 0, 0, 32'h0, 32'h0);
        step(1, 1, 32'h24, 32'hB2B2B2B2, 0, 0, 32'h0, 32'h0);
        step(1, 1, 32'h28, 32'hC3C3C3C3, 0, 0, 32'h0, 32'h0);
        step(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0);
        step(1, 0, 32'h28, 32'h0, 0, 0, 32'h24, 32'h0);
        idle();
        chk("t5_dma_rdata_held", dma_rdata, 32'hB2B2B2B2);

        // Randomized traffic; an ungranted master holds its request and fields
        cp = 0; dp = 0;
        cwe = 0; dwe = 0; ca = 32'h10; da = 32'h10; cd = '0; dd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!cp && $urandom_range(0, 99) < 65) begin
                cp = 1; cwe = 1'($urandom_range(0, 1));
                ca = 32'h10 + 32'(4 * $urandom_range(0, 11)); cd = $urandom;
            end
            if (!dp && $urandom_range(0, 99) < 65) begin
                dp = 1; dwe = 1'($urandom_range(0, 1));
                da = 32'h10 + 32'(4 * $urandom_range(0, 11)); dd = $urandom;
            end
            step(cp, cwe, ca, cd, dp, dwe, da, dd);
            if (last_cg) cp = 0;
            if (last_dg) dp = 0;
        end

        repeat (3) idle();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
